// File: rtl/stopwatch_pkg.sv
// Shared types and default constants for the stopwatch controller.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10,
      DONE  = 2'b11
   } sw_state_t;

   localparam int DEF_TIC_DIV   = 1000000;
   localparam int DEF_MAX_COUNT = 9999;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button, counter-feedback and control signals between the controller and the
// counter/display datapath. The controller is the slave side.
interface stopwatch_ctrl_if #(
   parameter int N = 14
);
   import stopwatch_pkg::*;

   logic            start_stop;
   logic            clear;
   logic [N-1:0]    count;
   logic            tic;
   logic            en;
   logic            cnt_clr;
   logic            running;
   logic            at_max;
   sw_state_t       state;

   modport master (
      output start_stop, clear, count,
      input  tic, en, cnt_clr, running, at_max, state
   );

   modport slave (
      input  start_stop, clear, count,
      output tic, en, cnt_clr, running, at_max, state
   );

endinterface

// File: rtl/tic_prescaler.sv
// Divides the system clock down to one terminal event every TIC_DIV advances.
// The count holds whenever advance is low, which is how a pause resumes
// mid-period.
module tic_prescaler
   import stopwatch_pkg::*;
#(
   parameter int TIC_DIV = DEF_TIC_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic advance,
   input  logic zero,
   output logic terminal
);

   localparam int            W    = (TIC_DIV > 1) ? $clog2(TIC_DIV) : 1;
   localparam logic [W-1:0]  LAST = W'(TIC_DIV - 1);

   logic [W-1:0] cnt_q;

   assign terminal = advance & (cnt_q == LAST);

   // Prescale counter: zero wins, otherwise count up and roll over at LAST.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (zero) begin
         cnt_q <= '0;
      end else if (advance) begin
         cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/idle/done sequencer. Turns the start/stop and clear
// buttons into counter tic/clear pulses and stops or wraps at MAX_COUNT.
// Every output comes straight from a flop.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int N         = 14,
   parameter int TIC_DIV   = DEF_TIC_DIV,
   parameter int MAX_COUNT = DEF_MAX_COUNT,
   parameter bit WRAP      = 1'b1
) (
   input logic             clk,
   input logic             rst,
   stopwatch_ctrl_if.slave bus
);

   localparam logic [N-1:0] MAX_VAL = N'(MAX_COUNT);

   sw_state_t state_q, state_d;
   logic      start_stop_q, clear_q;
   logic      ss_edge, clr_rise, at_top;
   logic      advance, zero, terminal;
   logic      tic_d, cnt_clr_d, run_d, done_d;
   logic      tic_q, cnt_clr_q, run_q, done_q;

   assign ss_edge  = bus.start_stop & ~start_stop_q;
   assign clr_rise = bus.clear & ~clear_q;
   // Anything past the terminal count is handled as the terminal count.
   assign at_top   = (bus.count >= MAX_VAL);
   assign advance  = (state_q == RUN) & ~ss_edge & ~bus.clear;
   assign zero     = bus.clear | ((state_q == IDLE) & ss_edge);

   tic_prescaler #(
      .TIC_DIV (TIC_DIV)
   ) u_prescaler (
      .clk      (clk),
      .rst      (rst),
      .advance  (advance),
      .zero     (zero),
      .terminal (terminal)
   );

   // State register, button history and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         // A start/stop button held through reset must not look like a press.
         start_stop_q <= 1'b1;
         clear_q      <= 1'b0;
         tic_q        <= 1'b0;
         cnt_clr_q    <= 1'b0;
         run_q        <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge values.
         state_q      <= state_d;
         start_stop_q <= bus.start_stop;
         clear_q      <= bus.clear;
         tic_q        <= tic_d;
         cnt_clr_q    <= cnt_clr_d;
         run_q        <= run_d;
         done_q       <= done_d;
      end
   end

   // Next state: clear overrides everything, then start/stop edges, then
   // the halt-at-terminal case.
   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch forms.
      state_d = state_q;
      if (bus.clear) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE:    if (ss_edge) state_d = RUN;
            RUN: begin
               if (ss_edge) begin
                  state_d = PAUSE;
               end else if (terminal && at_top && !WRAP) begin
                  state_d = DONE;
               end
            end
            PAUSE:   if (ss_edge) state_d = RUN;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Next output values. terminal already implies RUN without clear or
   // ss_edge, so tic and a clear-button pulse can never coincide.
   always_comb begin
      tic_d     = terminal & ~at_top;
      cnt_clr_d = clr_rise | (terminal & at_top & WRAP);
      run_d     = (state_d == RUN);
      done_d    = (state_d == DONE);
   end

   assign bus.tic     = tic_q;
   assign bus.cnt_clr = cnt_clr_q;
   assign bus.en      = run_q;
   assign bus.running = run_q;
   assign bus.at_max  = done_q;
   assign bus.state   = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with TIC_DIV=4, MAX_COUNT=5. Two instances share
// the button stimulus: index 0 wraps, index 1 halts in DONE. Each has its own
// behavioural counter, fed by the expected tic/clear pulses.
module tb_stopwatch_ctrl;

   localparam int N       = 14;
   localparam int TIC_DIV = 4;
   localparam int MAX_C   = 5;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_DONE  = 3;

   logic clk        = 1'b0;
   logic rst        = 1'b1;
   logic start_stop = 1'b1;
   logic clear      = 1'b0;

   int n_total = 0;
   int n_bad   = 0;

   // Reference model: mode encoded with the FSM state codes, RUN cycles that
   // advanced since the last restart, and the counter value.
   int           m_mode    [2] = '{M_IDLE, M_IDLE};
   int           m_runs    [2] = '{0, 0};
   int           m_count   [2] = '{0, 0};
   bit           m_ss_prev [2] = '{1'b1, 1'b1};
   bit           m_clr_prev[2] = '{1'b0, 1'b0};
   bit           e_tic     [2] = '{1'b0, 1'b0};
   bit           e_clr     [2] = '{1'b0, 1'b0};
   logic [N-1:0] cnt_drv   [2] = '{'0, '0};

   always #5 clk = ~clk;

   stopwatch_ctrl_if #(.N(N)) bus_w ();
   stopwatch_ctrl_if #(.N(N)) bus_h ();

   assign bus_w.start_stop = start_stop;
   assign bus_w.clear      = clear;
   assign bus_w.count      = cnt_drv[0];
   assign bus_h.start_stop = start_stop;
   assign bus_h.clear      = clear;
   assign bus_h.count      = cnt_drv[1];

   stopwatch_ctrl #(
      .N(N), .TIC_DIV(TIC_DIV), .MAX_COUNT(MAX_C), .WRAP(1'b1)
   ) dut_w (
      .clk (clk),
      .rst (rst),
      .bus (bus_w.slave)
   );

   stopwatch_ctrl #(
      .N(N), .TIC_DIV(TIC_DIV), .MAX_COUNT(MAX_C), .WRAP(1'b0)
   ) dut_h (
      .clk (clk),
      .rst (rst),
      .bus (bus_h.slave)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset(input int k);
      m_mode[k]     = M_IDLE;
      m_runs[k]     = 0;
      m_ss_prev[k]  = 1'b1;
      m_clr_prev[k] = 1'b0;
      e_tic[k]      = 1'b0;
      e_clr[k]      = 1'b0;
   endtask

   task automatic model_edge(input int k);
      bit ss_edge, clr_rise, at_top, n_tic, n_clr;
      int n_mode;
      ss_edge  = start_stop && !m_ss_prev[k];
      clr_rise = clear && !m_clr_prev[k];
      at_top   = (m_count[k] >= MAX_C);
      n_mode   = m_mode[k];
      n_tic    = 1'b0;
      n_clr    = 1'b0;
      if (clear) begin
         n_mode    = M_IDLE;
         m_runs[k] = 0;
         n_clr     = clr_rise;
      end else if (ss_edge) begin
         if (m_mode[k] == M_IDLE) begin
            n_mode    = M_RUN;
            m_runs[k] = 0;
         end else if (m_mode[k] == M_RUN) begin
            n_mode = M_PAUSE;
         end else if (m_mode[k] == M_PAUSE) begin
            n_mode = M_RUN;
         end
      end else if (m_mode[k] == M_RUN) begin
         m_runs[k]++;
         if (m_runs[k] % TIC_DIV == 0) begin
            if (!at_top)     n_tic  = 1'b1;
            else if (k == 0) n_clr  = 1'b1;
            else             n_mode = M_DONE;
         end
      end
      // The counter reacts to the pulses present before this edge.
      if (e_clr[k])      m_count[k] = 0;
      else if (e_tic[k]) m_count[k] = m_count[k] + 1;
      e_tic[k]      = n_tic;
      e_clr[k]      = n_clr;
      m_mode[k]     = n_mode;
      m_ss_prev[k]  = start_stop;
      m_clr_prev[k] = clear;
   endtask

   function automatic logic [6:0] exp_vec(input int k);
      return {2'(m_mode[k]), e_tic[k], m_mode[k] == M_RUN, e_clr[k],
              m_mode[k] == M_RUN, m_mode[k] == M_DONE};
   endfunction

   // Advance the model on every clock edge and on async reset.
   always @(posedge clk or posedge rst) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) model_reset(k);
         else     model_edge(k);
      end
   end

   // Present the model counter to the DUTs away from the sampling edge.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) cnt_drv[k] = N'(m_count[k]);
   end

   // Compare all outputs of both instances every cycle.
   always @(negedge clk) begin
      check("outs_wrap", {bus_w.state, bus_w.tic, bus_w.en, bus_w.cnt_clr,
                          bus_w.running, bus_w.at_max}, exp_vec(0));
      check("outs_halt", {bus_h.state, bus_h.tic, bus_h.en, bus_h.cnt_clr,
                          bus_h.running, bus_h.at_max}, exp_vec(1));
   end

   initial begin
      bit found;

      // 1: reset with start_stop held high.
      repeat (2) @(negedge clk);
      check("rst_outs", {bus_w.state, bus_w.tic, bus_w.en, bus_w.cnt_clr,
                         bus_w.running, bus_w.at_max}, 0);
      #1 rst = 1'b0;
      repeat (5) @(negedge clk);
      check("held_no_start", bus_w.state, M_IDLE);
      start_stop = 1'b0;
      @(negedge clk);
      check("release_idle", bus_w.state, M_IDLE);

      // 2: start, tics every 4 cycles.
      start_stop = 1'b1;
      @(negedge clk);
      check("start_state", bus_w.state, M_RUN);
      check("start_en", bus_w.en, 1);
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         check($sformatf("tic_c%0d", c), bus_w.tic, (c % TIC_DIV == 0));
      end
      start_stop = 1'b0;

      // 3: pause with prescaler at 2, resume 20 cycles later.
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (m_mode[0] == M_RUN && m_runs[0] % TIC_DIV == 2) found = 1'b1;
      end
      check("wait_pre2", found, 1);
      start_stop = 1'b1;
      @(negedge clk);
      check("pause_state", bus_w.state, M_PAUSE);
      check("pause_tic", bus_w.tic, 0);
      start_stop = 1'b0;
      repeat (20) @(negedge clk);
      check("paused_state", bus_w.state, M_PAUSE);
      start_stop = 1'b1;
      @(negedge clk);
      check("resume_state", bus_w.state, M_RUN);
      @(negedge clk);
      check("resume_c1", bus_w.tic, 0);
      @(negedge clk);
      check("resume_c2", bus_w.tic, 1);
      start_stop = 1'b0;

      // 4: reach MAX_COUNT; wrap vs halt.
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         if (e_clr[0]) found = 1'b1;
      end
      check("wait_wrap", found, 1);
      check("wrap_clr", bus_w.cnt_clr, 1);
      check("wrap_tic", bus_w.tic, 0);
      check("wrap_state", bus_w.state, M_RUN);
      check("halt_state", bus_h.state, M_DONE);
      check("halt_at_max", bus_h.at_max, 1);
      check("halt_en", bus_h.en, 0);
      for (int i = 0; i < 3; i++) begin
         start_stop = 1'b1;
         @(negedge clk);
         start_stop = 1'b0;
         repeat (6) @(negedge clk);
         check("halt_ignores_ss", bus_h.state, M_DONE);
         check("halt_no_tic", bus_h.tic, 0);
      end
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("clr_wrap_idle", bus_w.state, M_IDLE);
      check("clr_halt_idle", bus_h.state, M_IDLE);

      // 5: clear and start_stop edge together with prescaler at 3.
      @(negedge clk);
      start_stop = 1'b1;
      @(negedge clk);
      start_stop = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (m_mode[0] == M_RUN && m_runs[0] % TIC_DIV == 3) found = 1'b1;
      end
      check("wait_pre3", found, 1);
      clear      = 1'b1;
      start_stop = 1'b1;
      @(negedge clk);
      check("clr_win_state", bus_w.state, M_IDLE);
      check("clr_win_pulse", bus_w.cnt_clr, 1);
      check("clr_win_tic", bus_w.tic, 0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("clr_held_pulse", bus_w.cnt_clr, 0);
      end
      clear      = 1'b0;
      start_stop = 1'b0;
      @(negedge clk);
      start_stop = 1'b1;
      @(negedge clk);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         check($sformatf("restart_tic_c%0d", c), bus_w.tic, (c == 4));
      end
      start_stop = 1'b0;

      // 6: async reset between edges mid-RUN.
      repeat (6) @(negedge clk);
      check("pre_rst_running", bus_w.running, 1);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("async_rst_outs", {bus_w.tic, bus_w.en, bus_w.cnt_clr, bus_w.running}, 0);
      check("async_rst_state", bus_w.state, M_IDLE);
      @(negedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("post_rst_state", bus_w.state, M_IDLE);

      // Random phase against the model.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 11) == 0) start_stop = ~start_stop;
         if (clear) clear = ($urandom_range(0, 1) == 0);
         else       clear = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 499) == 0) begin
            #1 rst = 1'b1;
            @(negedge clk);
            #1 rst = 1'b0;
         end
      end

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
